// File: rtl/div_issue_pkg.sv
// Shared definitions for the divider issue controller.
//   - FSM state encoding
//   - default operand width and watchdog limit
//   - INT_MIN / ZERO operand constants at the default width
//   - watchdog counter width helper: $clog2(TIMEOUT+1)
package div_issue_pkg;

    localparam int unsigned DEFAULT_WIDTH   = 32;
    localparam int unsigned DEFAULT_TIMEOUT = 48;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [DEFAULT_WIDTH-1:0] INT_MIN = {1'b1, {(DEFAULT_WIDTH-1){1'b0}}};
    localparam logic [DEFAULT_WIDTH-1:0] ZERO    = '0;

    localparam int unsigned DEFAULT_WD_W = $clog2(DEFAULT_TIMEOUT + 1);

    // Counter width able to hold the value TIMEOUT itself.
    function automatic int unsigned wd_count_width(input int unsigned timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/div_watchdog.sv
// Watchdog up-counter for the divider RUN phase.
// Ports:
//   clk, clrn   clock, asynchronous active-low reset
//   i_clr       synchronous clear (has priority over i_inc)
//   i_inc       count enable; saturates at LIMIT
//   o_count     current count
//   o_last_c    combinational: count == LIMIT-1, the next increment reaches LIMIT
module div_watchdog #(
    parameter int unsigned LIMIT = 48,
    parameter int unsigned CNT_W = $clog2(LIMIT + 1)
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count,
    output logic             o_last_c
);

    logic [CNT_W-1:0] r_count;

    // Count register: clear wins, saturate at LIMIT.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != CNT_W'(LIMIT))) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count  = r_count;
    assign o_last_c = (r_count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/div_issue_ctrl.sv
// Issue sequencer for the multi-cycle signed divider.
// Latches operands on start, clears and runs the divider, captures the
// quotient, flags divide-by-zero and watchdog timeout.
// Optional feature macro: DIV_OVERFLOW_TRAP_EN (traps INT_MIN / -1 without
// starting the divider).
// Ports:
//   clk, clrn                   clock, asynchronous active-low reset
//   start                       one-cycle request, operands sampled with it
//   dividend_in, divisor_in     signed operands
//   busy                        operation in flight (CLEAR/RUN/DONE)
//   result, exception           quotient and error flag, held until next start
//   result_rdy                  one-cycle result valid pulse
//   div_dividend, div_divisor   latched operands to the divider
//   div_clrn, div_ena           divider clear (active low) and enable
//   div_out, div_ready          divider quotient and completion
module div_issue_ctrl
    import div_issue_pkg::*;
#(
    parameter int unsigned WIDTH   = DEFAULT_WIDTH,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend_in,
    input  logic [WIDTH-1:0] divisor_in,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             exception,
    output logic             result_rdy,
    output logic [WIDTH-1:0] div_dividend,
    output logic [WIDTH-1:0] div_divisor,
    output logic             div_clrn,
    output logic             div_ena,
    input  logic [WIDTH-1:0] div_out,
    input  logic             div_ready
);

    localparam int unsigned WD_W = wd_count_width(TIMEOUT);

    state_t           r_state;
    logic [WIDTH-1:0] r_dividend;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_result;
    logic             r_busy;
    logic             r_exception;
    logic             r_result_rdy;
    logic             r_div_clrn;
    logic             r_div_ena;

    logic [WD_W-1:0]  w_wd_count;
    logic             w_wd_last;
    logic             w_in_run;
    logic             w_first_run;
    logic             w_div_by_zero;

    assign w_in_run      = (r_state == ST_RUN);
    assign w_first_run   = (w_wd_count == '0);
    assign w_div_by_zero = (divisor_in == '0);

`ifdef DIV_OVERFLOW_TRAP_EN
    localparam logic [WIDTH-1:0] W_INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    logic w_overflow;
    assign w_overflow = (dividend_in == W_INT_MIN) && (divisor_in == '1);
`endif

    // Counts RUN cycles; cleared whenever the FSM is outside RUN.
    div_watchdog #(
        .LIMIT (TIMEOUT),
        .CNT_W (WD_W)
    ) u_watchdog (
        .clk      (clk),
        .clrn     (clrn),
        .i_clr    (~w_in_run),
        .i_inc    (w_in_run),
        .o_count  (w_wd_count),
        .o_last_c (w_wd_last)
    );

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state      <= ST_IDLE;
            r_dividend   <= '0;
            r_divisor    <= '0;
            r_result     <= '0;
            r_busy       <= 1'b0;
            r_exception  <= 1'b0;
            r_result_rdy <= 1'b0;
            r_div_clrn   <= 1'b0;
            r_div_ena    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_div_clrn <= 1'b1;
                    if (start) begin
                        r_dividend  <= dividend_in;
                        r_divisor   <= divisor_in;
                        r_exception <= 1'b0;
                        r_busy      <= 1'b1;
                        if (w_div_by_zero) begin
                            r_result     <= '0;
                            r_exception  <= 1'b1;
                            r_result_rdy <= 1'b1;
                            r_state      <= ST_DONE;
`ifdef DIV_OVERFLOW_TRAP_EN
                        end else if (w_overflow) begin
                            r_result     <= W_INT_MIN;
                            r_exception  <= 1'b1;
                            r_result_rdy <= 1'b1;
                            r_state      <= ST_DONE;
`endif
                        end else begin
                            // Clear pulse lasts exactly the CLEAR cycle.
                            r_div_clrn <= 1'b0;
                            r_state    <= ST_CLEAR;
                        end
                    end
                end

                ST_CLEAR: begin
                    r_div_clrn <= 1'b1;
                    r_div_ena  <= 1'b1;
                    r_state    <= ST_RUN;
                end

                ST_RUN: begin
                    // div_ready is stale in the first cycle after the clear.
                    if (div_ready && !w_first_run) begin
                        r_result     <= div_out;
                        r_div_ena    <= 1'b0;
                        r_result_rdy <= 1'b1;
                        r_state      <= ST_DONE;
                    end else if (w_wd_last) begin
                        r_result     <= '0;
                        r_exception  <= 1'b1;
                        r_div_ena    <= 1'b0;
                        r_result_rdy <= 1'b1;
                        r_state      <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    r_result_rdy <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy         = r_busy;
    assign result       = r_result;
    assign exception    = r_exception;
    assign result_rdy   = r_result_rdy;
    assign div_dividend = r_dividend;
    assign div_divisor  = r_divisor;
    assign div_clrn     = r_div_clrn;
    assign div_ena      = r_div_ena;

endmodule
